// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Accepts one execute result at a time. ALU results pass straight to writeback.
// Loads and stores are issued on a req/gnt data-memory port, with lane steering
// for byte/half stores and lane extraction plus sign/zero extension for loads.
// Optional build macro MEM_MISALIGN_CHECK_EN: a misaligned half/word access
// issues no memory request and completes with M_misalign_o=1 and the faulting
// address on M_valM_o. Without the macro, the offending low address bits of a
// half/word access are ignored.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst,
    input  logic            E_valid_i,
    output logic            E_ready_o,
    input  logic [XLEN-1:0] E_valE_i,
    input  logic [XLEN-1:0] E_rs2_data_i,
    input  logic            E_load_i,
    input  logic            E_store_i,
    input  logic [2:0]      E_funct3_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_wstrb_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            M_valid_o,
    output logic [XLEN-1:0] M_valM_o,
    output logic            M_misalign_o,
    input  logic            W_ready_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_funct3;
    logic            r_store;
    logic [XLEN-1:0] r_valM;
    logic [XLEN-1:0] w_valM_nxt;
    logic            w_valM_we;
    logic            w_latch;
    logic            w_mem_op;
    logic            w_mis_in;
    logic [1:0]      w_off;
    logic [3:0]      w_strb;
    logic [XLEN-1:0] w_st_data;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;

    assign w_mem_op = E_load_i | E_store_i;

`ifdef MEM_MISALIGN_CHECK_EN
    logic r_misalign;

    // Alignment check on the incoming effective address (funct3[1:0]: 01 half, 1x word)
    always_comb begin
        w_mis_in = 1'b0;
        if (E_funct3_i[1:0] == 2'b01)
            w_mis_in = E_valE_i[0];
        else if (E_funct3_i[1])
            w_mis_in = (E_valE_i[1:0] != 2'b00);
    end

    // Misalign flag captured alongside the result; only a faulting transfer from IDLE sets it
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst)
            r_misalign <= 1'b0;
        else if (w_valM_we)
            r_misalign <= (r_state == IDLE) && w_mem_op && w_mis_in;
    end

    assign M_misalign_o = r_misalign;
`else
    assign w_mis_in     = 1'b0;
    assign M_misalign_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state and result-capture decisions
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_valM_we   = 1'b0;
        w_valM_nxt  = r_valM;
        case (r_state)
            IDLE: begin
                if (E_valid_i) begin
                    if (!w_mem_op || w_mis_in) begin
                        w_state_nxt = HOLD;
                        w_valM_we   = 1'b1;
                        w_valM_nxt  = E_valE_i;
                    end else begin
                        w_state_nxt = REQ;
                        w_latch     = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    if (r_store) begin
                        w_state_nxt = HOLD;
                        w_valM_we   = 1'b1;
                        w_valM_nxt  = '0;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    w_state_nxt = HOLD;
                    w_valM_we   = 1'b1;
                    w_valM_nxt  = w_load_data;
                end
            end
            HOLD: begin
                if (W_ready_i)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Transaction latch: address, store data, size and direction (store wins over load)
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
            r_store  <= 1'b0;
        end else if (w_latch) begin
            r_addr   <= E_valE_i;
            r_wdata  <= E_rs2_data_i;
            r_funct3 <= E_funct3_i;
            r_store  <= E_store_i;
        end
    end

    // Result register presented to writeback
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst)
            r_valM <= '0;
        else if (w_valM_we)
            r_valM <= w_valM_nxt;
    end

    // Effective byte lane: half ignores addr[0], word ignores addr[1:0]
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_off = r_addr[1:0];
            2'b01:   w_off = {r_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    // Store lane steering and data replication
    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_strb    = 4'b0001 << w_off;
                w_st_data = {(XLEN/8){r_wdata[7:0]}};
            end
            2'b01: begin
                w_strb    = 4'b0011 << w_off;
                w_st_data = {(XLEN/16){r_wdata[15:0]}};
            end
            default: begin
                w_strb    = 4'b1111;
                w_st_data = r_wdata;
            end
        endcase
    end

    // Load lane extraction with sign/zero extension (funct3[2] selects unsigned)
    always_comb begin
        case (w_off)
            2'b00:   w_byte = dmem_rdata_i[7:0];
            2'b01:   w_byte = dmem_rdata_i[15:8];
            2'b10:   w_byte = dmem_rdata_i[23:16];
            default: w_byte = dmem_rdata_i[31:24];
        endcase
        w_half = w_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (r_funct3[1:0])
            2'b00:   w_load_data = {{(XLEN-8){~r_funct3[2] & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{(XLEN-16){~r_funct3[2] & w_half[15]}}, w_half};
            default: w_load_data = dmem_rdata_i;
        endcase
    end

    // Memory port is driven only while requesting, so it reads as zero elsewhere
    always_comb begin
        dmem_req_o   = (r_state == REQ);
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wstrb_o = '0;
        dmem_wdata_o = '0;
        if (r_state == REQ) begin
            dmem_we_o    = r_store;
            dmem_addr_o  = {r_addr[XLEN-1:2], 2'b00};
            dmem_wstrb_o = w_strb;
            dmem_wdata_o = w_st_data;
        end
    end

    assign E_ready_o = (r_state == IDLE);
    assign M_valid_o = (r_state == HOLD);
    assign M_valM_o  = r_valM;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage. A single process drives transactions and, in
// tick(), compares every cycle's outputs against expectations derived from an
// arithmetic model of the load/store rules.
module tb_mem_stage;
    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst = 1'b0;
    logic            E_valid_i, E_ready_o, E_load_i, E_store_i;
    logic [XLEN-1:0] E_valE_i, E_rs2_data_i;
    logic [2:0]      E_funct3_i;
    logic            dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
    logic [XLEN-1:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]      dmem_wstrb_o;
    logic            M_valid_o, M_misalign_o, W_ready_i;
    logic [XLEN-1:0] M_valM_o;

    mem_stage #(.XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst(rst),
        .E_valid_i(E_valid_i), .E_ready_o(E_ready_o),
        .E_valE_i(E_valE_i), .E_rs2_data_i(E_rs2_data_i),
        .E_load_i(E_load_i), .E_store_i(E_store_i), .E_funct3_i(E_funct3_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wstrb_o(dmem_wstrb_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .M_valid_o(M_valid_o), .M_valM_o(M_valM_o), .M_misalign_o(M_misalign_o),
        .W_ready_i(W_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    bit          chk_on = 1'b0;
    bit          exp_ready, exp_req, exp_valid, exp_mis, e_we;
    logic [31:0] e_addr, e_wdata, e_valM;
    logic [3:0]  e_strb;
    int          n_req_cyc = 0;
    int          n_compl   = 0;
    logic [31:0] cap_valM, cap_addr, cap_wdata;
    logic [3:0]  cap_strb;
    logic        cap_mis, cap_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: store byte strobes
    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
        int unsigned lane = a % 4;
        if (f3[1:0] == 2'b00) return 4'(1 << lane);
        if (f3[1:0] == 2'b01) return 4'(3 << ((lane / 2) * 2));
        return 4'hF;
    endfunction

    // Model: store data replication
    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return (d % 256) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    // Model: load lane extraction and extension using plain arithmetic
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int unsigned     lane;
        longint unsigned v;
        lane = (f3[1:0] == 2'b00) ? (a % 4) : (f3[1:0] == 2'b01) ? ((a % 4) / 2) * 2 : 0;
        v = longint'(rd) / (64'd1 << (8 * lane));
        if (f3[1:0] == 2'b00) begin
            v = v % 256;
            if (!f3[2] && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (f3[1:0] == 2'b01) begin
            v = v % 65536;
            if (!f3[2] && v >= 32768) v = v + 64'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v[31:0];
    endfunction

    function automatic bit model_misal(input logic [2:0] f3, input logic [31:0] a);
        bit en;
`ifdef MEM_MISALIGN_CHECK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && ((f3[1:0] == 2'b01 && a % 2 != 0) || (f3[1:0] == 2'b10 && a % 4 != 0));
    endfunction

    // One cycle: compare at negedge, then advance to just after the next rising edge
    task automatic tick();
        @(negedge clk_i);
        if (chk_on) begin
            chk("E_ready", E_ready_o, exp_ready);
            chk("dmem_req", dmem_req_o, exp_req);
            chk("M_valid", M_valid_o, exp_valid);
            if (exp_req) begin
                chk("dmem_addr", dmem_addr_o, e_addr);
                chk("dmem_wstrb", dmem_wstrb_o, e_strb);
                chk("dmem_we", dmem_we_o, e_we);
                if (e_we) chk("dmem_wdata", dmem_wdata_o, e_wdata);
            end
            if (exp_valid) begin
                chk("M_valM", M_valM_o, e_valM);
                chk("M_misalign", M_misalign_o, exp_mis);
            end
            if (dmem_req_o) begin
                n_req_cyc++;
                cap_addr  = dmem_addr_o;
                cap_strb  = dmem_wstrb_o;
                cap_wdata = dmem_wdata_o;
                cap_we    = dmem_we_o;
            end
            if (M_valid_o) begin
                cap_valM = M_valM_o;
                cap_mis  = M_misalign_o;
                if (W_ready_i) n_compl++;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rs2,
                          input int gnt_dly, input logic [31:0] rdata,
                          input int rv_dly, input int wr_dly, input bit rv_with_gnt);
        int  c0;
        bit  memop, misal;
        memop   = ld | st;
        misal   = memop && model_misal(f3, a);
        e_we    = st;
        e_addr  = a & 32'hFFFF_FFFC;
        e_strb  = model_strb(f3, a);
        e_wdata = model_wdata(f3, rs2);
        exp_mis = misal;
        if (misal || !memop) e_valM = a;
        else if (st)         e_valM = 32'h0;
        else                 e_valM = model_load(f3, a, rdata);
        c0 = n_compl;

        E_valid_i = 1'b1; E_load_i = ld; E_store_i = st; E_funct3_i = f3;
        E_valE_i = a; E_rs2_data_i = rs2;
        tick();
        E_valid_i = 1'b0; E_load_i = 1'b0; E_store_i = 1'b0;
        E_valE_i = 32'hDEAD_BEEF; E_rs2_data_i = 32'h5A5A_5A5A; E_funct3_i = 3'b111;
        exp_ready = 1'b0;
        if (memop && !misal) begin
            exp_req = 1'b1;
            repeat (gnt_dly) tick();
            dmem_gnt_i = 1'b1;
            if (rv_with_gnt) begin
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = ~rdata;
            end
            tick();
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
            exp_req = 1'b0;
            if (!st) begin
                repeat (rv_dly) tick();
                dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
                tick();
                dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0BAD_0BAD;
            end
        end
        exp_valid = 1'b1;
        if (wr_dly > 0) begin
            W_ready_i = 1'b0;
            repeat (wr_dly) tick();
            W_ready_i = 1'b1;
        end
        tick();
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        chk("completions", n_compl - c0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        E_valid_i = 1'b0; E_load_i = 1'b0; E_store_i = 1'b0; E_funct3_i = 3'b000;
        E_valE_i = '0; E_rs2_data_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        W_ready_i = 1'b1;
        exp_ready = 1'b1; exp_req = 1'b0; exp_valid = 1'b0; exp_mis = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_wstrb", dmem_wstrb_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_valid", M_valid_o, 0);
        chk("rst_valM", M_valM_o, 0);
        chk("rst_misalign", M_misalign_o, 0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst = 1'b0;
        chk_on = 1'b1;
        tick();

        // ALU pass-through
        r0 = n_req_cyc;
        run_op(0, 0, 3'b010, 32'h1234_5678, 32'h0, 0, 32'h0, 0, 0, 0);
        chk("alu_valM", cap_valM, 32'h1234_5678);
        chk("alu_noreq", n_req_cyc - r0, 0);

        // SB with grant delayed 3 cycles
        r0 = n_req_cyc;
        run_op(0, 1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 3, 32'h0, 0, 0, 0);
        chk("sb_reqcyc", n_req_cyc - r0, 4);
        chk("sb_addr", cap_addr, 32'h0000_1000);
        chk("sb_wstrb", cap_strb, 4'b1000);
        chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        chk("sb_valM", cap_valM, 32'h0);

        // Loads; rvalid alongside grant must be ignored
        run_op(1, 0, 3'b000, 32'h0000_2001, 32'h0, 1, 32'h0000_8000, 2, 0, 1);
        chk("lb_valM", cap_valM, 32'hFFFF_FF80);
        run_op(1, 0, 3'b100, 32'h0000_2001, 32'h0, 0, 32'h0000_8000, 0, 0, 1);
        chk("lbu_valM", cap_valM, 32'h0000_0080);
        run_op(1, 0, 3'b101, 32'h0000_2002, 32'h0, 0, 32'hBEEF_0000, 1, 0, 0);
        chk("lhu_valM", cap_valM, 32'h0000_BEEF);
        run_op(1, 0, 3'b001, 32'h0000_2002, 32'h0, 2, 32'hBEEF_0000, 0, 0, 0);
        chk("lh_valM", cap_valM, 32'hFFFF_BEEF);
        run_op(1, 0, 3'b000, 32'h0000_2003, 32'h0, 0, 32'h7F00_0000, 0, 0, 0);
        chk("lb3_valM", cap_valM, 32'h0000_007F);

        // Writeback back-pressure for 5 cycles
        run_op(1, 0, 3'b010, 32'h0000_3000, 32'h0, 0, 32'hCAFE_F00D, 1, 5, 0);
        chk("lw_bp_valM", cap_valM, 32'hCAFE_F00D);

        // Half and word stores; load+store together behaves as store
        run_op(0, 1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 0, 32'h0, 0, 0, 0);
        chk("sh_wstrb", cap_strb, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        run_op(0, 1, 3'b010, 32'h0000_1004, 32'h89AB_CDEF, 1, 32'h0, 0, 0, 0);
        chk("sw_wstrb", cap_strb, 4'b1111);
        chk("sw_addr", cap_addr, 32'h0000_1004);
        run_op(1, 1, 3'b010, 32'h0000_1008, 32'h55AA_55AA, 0, 32'h1111_1111, 0, 0, 0);
        chk("ldst_we", cap_we, 1);
        chk("ldst_valM", cap_valM, 32'h0);

        // Misaligned word load
        r0 = n_req_cyc;
        run_op(1, 0, 3'b010, 32'h0000_3002, 32'h0, 0, 32'h1122_3344, 0, 0, 0);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("lw_mis_noreq", n_req_cyc - r0, 0);
        chk("lw_mis_flag", cap_mis, 1);
        chk("lw_mis_valM", cap_valM, 32'h0000_3002);
`else
        chk("lw_mis_addr", cap_addr, 32'h0000_3000);
        chk("lw_mis_flag", cap_mis, 0);
        chk("lw_mis_valM", cap_valM, 32'h1122_3344);
`endif

        // Reset while waiting for load data, then a stray rvalid in IDLE
        e_addr = 32'h0000_4000; e_strb = 4'b1111; e_we = 1'b0;
        E_valid_i = 1'b1; E_load_i = 1'b1; E_funct3_i = 3'b010; E_valE_i = 32'h0000_4000;
        tick();
        E_valid_i = 1'b0; E_load_i = 1'b0;
        exp_ready = 1'b0; exp_req = 1'b1;
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0; exp_req = 1'b0;
        tick();
        chk_on = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstw_valid", M_valid_o, 0);
        chk("rstw_req", dmem_req_o, 0);
        chk("rstw_valM", M_valM_o, 0);
        tick();
        rst = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
        chk_on = 1'b1; exp_ready = 1'b1; exp_valid = 1'b0; exp_req = 1'b0;
        tick();
        dmem_rvalid_i = 1'b0;
        repeat (3) tick();
        chk("rstw_valM_after", M_valM_o, 0);

        // Pass-through still works after the abandoned transaction
        run_op(0, 0, 3'b000, 32'hA5A5_0001, 32'h0, 0, 32'h0, 0, 0, 0);
        chk("alu2_valM", cap_valM, 32'hA5A5_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
